uart_rx_ctrl: RTL and testbench

Receive-side sequencer for the UART RX path. It detects the start edge, runs the oversampling edge/bit counters, and enables the data sampler and deserializer. It also gates the start/parity/stop checkers and issues the data_valid strobe. It sits between the RX pin synchroniser and the data_sampler/deserializer/checker datapath.

---
 rtl/uart_rx_pkg.sv | 24 ++
 rtl/uart_rx_ctrl_if.sv | 44 ++++
 rtl/uart_rx_edge_bit_cnt.sv | 43 ++++
 rtl/uart_rx_ctrl.sv | 153 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive sequencer.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int unsigned PS_8  = 8;
    localparam int unsigned PS_16 = 16;
    localparam int unsigned PS_32 = 32;

    // Only these oversampling ratios keep edge_cnt inside its 5-bit range
    // and give the sampler a well-defined mid-bit window.
    function automatic logic prescale_legal(input int unsigned ps);
        return (ps == PS_8) || (ps == PS_16) || (ps == PS_32);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Sideband bundle between the RX sequencer and the sampler/deserializer/checker datapath.
// Latency: none (wires only).
// Backpressure: none; the serial line cannot be stalled, every strobe is fire-and-forget.
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PS_W       = 6
);
    localparam int BC_W = $clog2(DATA_WIDTH + 3);

    // line and configuration
    logic              RX_in;
    logic [PS_W-1:0]   prescale;
    logic              PAR_EN;
    // checker results
    logic              strt_glitch;
    logic              par_err;
    logic              stp_err;
    // sequencer outputs
    logic              dat_samp_en;
    logic [4:0]        edge_cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic              deser_en;
    logic              strt_chk_en;
    logic              par_chk_en;
    logic              stp_chk_en;
    logic              data_valid;
    logic              frame_err;
    logic              parity_err;

    modport master (
        input  RX_in, prescale, PAR_EN, strt_glitch, par_err, stp_err,
        output dat_samp_en, edge_cnt, bit_cnt, deser_en,
               strt_chk_en, par_chk_en, stp_chk_en,
               data_valid, frame_err, parity_err
    );

    modport slave (
        output RX_in, prescale, PAR_EN, strt_glitch, par_err, stp_err,
        input  dat_samp_en, edge_cnt, bit_cnt, deser_en,
               strt_chk_en, par_chk_en, stp_chk_en,
               data_valid, frame_err, parity_err
    );

endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and frame bit counter with last-edge flag.
// Latency: counters update on the clock edge; last_edge is combinational from the counters.
// Backpressure: none; counts every cycle while enabled, clear has priority.
module uart_rx_edge_bit_cnt #(
    parameter int PS_W = 6,
    parameter int BC_W = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            en,
    input  logic            clr,
    input  logic [PS_W-1:0] ps_q,
    output logic [4:0]      edge_cnt,
    output logic [BC_W-1:0] bit_cnt,
    output logic            last_edge
);

    logic [PS_W-1:0] ps_m1;

    // Terminal count is computed at full prescale width, then truncated so
    // a 32x ratio compares against 31.
    assign ps_m1     = ps_q - PS_W'(1);
    assign last_edge = en && (edge_cnt == ps_m1[4:0]);

    // Edge index wraps at the end of each bit and advances the bit index.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (en) begin
            if (last_edge) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + BC_W'(1);
            end else begin
                edge_cnt <= edge_cnt + 5'd1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detect, bit timing, sampler/deser/checker enables, frame result.
// Latency: enables are combinational on each bit's last edge; frame result strobes 1 cycle after the stop last edge.
// Backpressure: none; the serial line cannot be stalled and every strobe is a single-cycle pulse.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PS_W       = 6
) (
    input  logic            CLK,
    input  logic            RST,
    uart_rx_ctrl_if.master  bus
);

    localparam int BC_W = $clog2(DATA_WIDTH + 3);

    rx_state_e       state_q;
    rx_state_e       state_d;
    logic [PS_W-1:0] ps_q;
    logic            par_q;
    logic            par_err_q;
    logic            data_valid_q;
    logic            frame_err_q;
    logic            parity_err_q;

    logic            cnt_en;
    logic            cnt_clr;
    logic            frame_start;
    logic            last_edge;
    logic            ps_ok;
    logic            stop_done;
    logic [4:0]      edge_cnt;
    logic [BC_W-1:0] bit_cnt;

    assign ps_ok     = prescale_legal(32'(bus.prescale));
    assign cnt_en    = (state_q != IDLE);
    assign stop_done = (state_q == STOP) && last_edge;

    uart_rx_edge_bit_cnt #(
        .PS_W (PS_W),
        .BC_W (BC_W)
    ) u_cnt (
        .CLK       (CLK),
        .RST       (RST),
        .en        (cnt_en),
        .clr       (cnt_clr),
        .ps_q      (ps_q),
        .edge_cnt  (edge_cnt),
        .bit_cnt   (bit_cnt),
        .last_edge (last_edge)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; also decides when the counters restart and when a
    // new frame latches its configuration (including back-to-back frames).
    always_comb begin
        state_d     = state_q;
        cnt_clr     = 1'b0;
        frame_start = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!bus.RX_in && ps_ok) begin
                    state_d     = START;
                    frame_start = 1'b1;
                end
            end
            START: begin
                if (last_edge) begin
                    if (bus.strt_glitch) begin
                        state_d = IDLE;
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (last_edge && (bit_cnt == BC_W'(DATA_WIDTH))) begin
                    state_d = par_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (last_edge) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (last_edge) begin
                    cnt_clr = 1'b1;
                    if (!bus.RX_in && ps_ok) begin
                        state_d     = START;
                        frame_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Frame configuration is frozen at frame start; parity verdict held until the stop bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ps_q      <= '0;
            par_q     <= 1'b0;
            par_err_q <= 1'b0;
        end else if (frame_start) begin
            ps_q      <= bus.prescale;
            par_q     <= bus.PAR_EN;
            par_err_q <= 1'b0;
        end else if ((state_q == PARITY) && last_edge) begin
            par_err_q <= bus.par_err;
        end
    end

    // Frame result: registered off the stop last edge, so each strobe lasts one cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            data_valid_q <= stop_done && !par_err_q && !bus.stp_err;
            frame_err_q  <= stop_done && bus.stp_err;
            parity_err_q <= stop_done && par_err_q;
        end
    end

    assign bus.dat_samp_en = (state_q != IDLE);
    assign bus.edge_cnt    = edge_cnt;
    assign bus.bit_cnt     = bit_cnt;
    assign bus.strt_chk_en = (state_q == START)  && last_edge;
    assign bus.deser_en    = (state_q == DATA)   && last_edge;
    assign bus.par_chk_en  = (state_q == PARITY) && last_edge;
    assign bus.stp_chk_en  = stop_done;
    assign bus.data_valid  = data_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.parity_err  = parity_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for the UART receive sequencer.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    uart_rx_ctrl_if #(.DATA_WIDTH(8), .PS_W(6)) bus ();

    uart_rx_ctrl #(.DATA_WIDTH(8), .PS_W(6)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int gcyc   = 0;

    always @(posedge CLK) gcyc <= gcyc + 1;

    // event log, timestamped with the cycle count seen at the falling edge
    int   deser_q[$];
    int   valid_q[$];
    int   ferr_q[$];
    int   perr_q[$];
    int   parchk_q[$];
    int   fall_q[$];
    int   pc_edge;
    int   pc_bit;
    logic samp_prev = 1'b0;

    always @(negedge CLK) begin
        if (bus.deser_en === 1'b1)   deser_q.push_back(gcyc);
        if (bus.data_valid === 1'b1) valid_q.push_back(gcyc);
        if (bus.frame_err === 1'b1)  ferr_q.push_back(gcyc);
        if (bus.parity_err === 1'b1) perr_q.push_back(gcyc);
        if (bus.par_chk_en === 1'b1) begin
            if (parchk_q.size() == 0) begin
                pc_edge = int'(bus.edge_cnt);
                pc_bit  = int'(bus.bit_cnt);
            end
            parchk_q.push_back(gcyc);
        end
        if (samp_prev === 1'b1 && bus.dat_samp_en === 1'b0) fall_q.push_back(gcyc);
        samp_prev = bus.dat_samp_en;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs_word();
        logic [16:0] w;
        w = {bus.dat_samp_en, bus.edge_cnt, bus.bit_cnt, bus.deser_en,
             bus.strt_chk_en, bus.par_chk_en, bus.stp_chk_en,
             bus.data_valid, bus.frame_err, bus.parity_err};
        if ($isunknown(w)) return -1;
        return int'(w);
    endfunction

    task automatic clear_log();
        deser_q.delete();
        valid_q.delete();
        ferr_q.delete();
        perr_q.delete();
        parchk_q.delete();
        fall_q.delete();
        pc_edge = -1;
        pc_bit  = -1;
    endtask

    task automatic idle(input int n);
        bus.RX_in = 1'b1;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Drives one frame on the line, called just after a rising edge. Returns
    // after the stop bit; with b2b the line is left low to start the next frame.
    task automatic send_frame(input logic [5:0] ps, input logic [5:0] ps_mid,
                              input logic par_en, input logic [7:0] data,
                              input logic perr, input logic serr, input logic glitch,
                              input logic b2b, output int base);
        logic [10:0] bits;
        int psi;
        int nbits;
        psi   = int'(ps);
        nbits = par_en ? 11 : 10;
        bits  = '1;
        bits[0]   = 1'b0;
        bits[8:1] = data;
        if (par_en) bits[9] = ^data;
        base = gcyc;
        bus.prescale = ps;
        bus.PAR_EN   = par_en;
        for (int c = 0; c < nbits * psi; c++) begin
            if (c == 1) begin
                bus.par_err     = perr;
                bus.stp_err     = serr;
                bus.strt_glitch = glitch;
            end
            if (c == 20) bus.prescale = ps_mid;
            bus.RX_in = bits[c / psi];
            @(posedge CLK);
            #1;
        end
        if (b2b) begin
            bus.RX_in = 1'b0;
        end else begin
            bus.RX_in = 1'b1;
            @(posedge CLK);
            #1;
            bus.par_err     = 1'b0;
            bus.stp_err     = 1'b0;
            bus.strt_glitch = 1'b0;
        end
    endtask

    typedef struct {
        logic [5:0] ps;
        logic [5:0] ps_mid;
        logic       par_en;
        logic [7:0] data;
        logic       perr;
        logic       serr;
        logic       glitch;
        int exp_deser;
        int exp_first_deser;
        int exp_valid;
        int exp_ferr;
        int exp_perr;
        int exp_strobe;
        int exp_parchk;
        int exp_pc_edge;
        int exp_pc_bit;
        int exp_idle;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int base;
        int base2;
        int bad;
        int first;
        int strobe;

        bus.RX_in       = 1'b1;
        bus.prescale    = 6'd8;
        bus.PAR_EN      = 1'b0;
        bus.strt_glitch = 1'b0;
        bus.par_err     = 1'b0;
        bus.stp_err     = 1'b0;

        //            ps  mid par data   pe se gl  dsr 1st v f p  strb  pc e  b  idle
        vecs[0] = '{6'd8,  6'd8,  1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 8, 16, 1, 0, 0,  81, 0,  0, 0,  81};
        vecs[1] = '{6'd16, 6'd16, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 8, 32, 0, 0, 1, 177, 1, 15, 9, 177};
        vecs[2] = '{6'd32, 6'd32, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 0, -1, 0, 0, 0,  -1, 0,  0, 0,  33};
        vecs[3] = '{6'd8,  6'd8,  1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8, 16, 0, 1, 0,  81, 0,  0, 0,  81};
        vecs[4] = '{6'd16, 6'd16, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 8, 32, 1, 0, 0, 177, 1, 15, 9, 177};
        vecs[5] = '{6'd32, 6'd32, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8, 64, 1, 0, 0, 321, 0,  0, 0, 321};
        vecs[6] = '{6'd8,  6'd8,  1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8, 16, 0, 1, 1,  89, 1,  7, 9,  89};
        vecs[7] = '{6'd8,  6'd16, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 8, 16, 1, 0, 0,  81, 0,  0, 0,  81};

        // reset state
        #2 RST = 1'b0;
        #1 check("reset_outs", outs_word(), 0);
        repeat (3) @(posedge CLK);
        #1 check("reset_hold_outs", outs_word(), 0);
        @(negedge CLK) RST = 1'b1;
        @(posedge CLK);
        #1;
        idle(3);
        check("idle_outs", outs_word(), 0);

        // table-driven frames
        for (int i = 0; i < 8; i++) begin
            clear_log();
            send_frame(vecs[i].ps, vecs[i].ps_mid, vecs[i].par_en, vecs[i].data,
                       vecs[i].perr, vecs[i].serr, vecs[i].glitch, 1'b0, base);
            idle(4);
            first = (deser_q.size() > 0) ? deser_q[0] - base : -1;
            bad = 0;
            for (int k = 1; k < deser_q.size(); k++)
                if (deser_q[k] - deser_q[k-1] != int'(vecs[i].ps)) bad++;
            strobe = -1;
            if (valid_q.size() > 0) strobe = valid_q[0] - base;
            else if (ferr_q.size() > 0) strobe = ferr_q[0] - base;
            else if (perr_q.size() > 0) strobe = perr_q[0] - base;
            check($sformatf("v%0d_deser_count", i), deser_q.size(), vecs[i].exp_deser);
            check($sformatf("v%0d_deser_first", i), first, vecs[i].exp_first_deser);
            check($sformatf("v%0d_deser_spacing_bad", i), bad, 0);
            check($sformatf("v%0d_data_valid_count", i), valid_q.size(), vecs[i].exp_valid);
            check($sformatf("v%0d_frame_err_count", i), ferr_q.size(), vecs[i].exp_ferr);
            check($sformatf("v%0d_parity_err_count", i), perr_q.size(), vecs[i].exp_perr);
            check($sformatf("v%0d_strobe_cycle", i), strobe, vecs[i].exp_strobe);
            check($sformatf("v%0d_par_chk_count", i), parchk_q.size(), vecs[i].exp_parchk);
            if (vecs[i].exp_parchk > 0) begin
                check($sformatf("v%0d_par_chk_edge", i), pc_edge, vecs[i].exp_pc_edge);
                check($sformatf("v%0d_par_chk_bit", i), pc_bit, vecs[i].exp_pc_bit);
            end
            check($sformatf("v%0d_idle_return", i),
                  (fall_q.size() > 0) ? fall_q[0] - base : -1, vecs[i].exp_idle);
        end

        // illegal prescale: line low must not start a frame
        clear_log();
        bus.prescale = 6'd12;
        bus.RX_in    = 1'b0;
        bad = 0;
        repeat (20) begin
            @(posedge CLK);
            #1;
            if (bus.dat_samp_en !== 1'b0 || bus.edge_cnt !== 5'd0) bad++;
        end
        check("illegal_ps_stays_idle", bad, 0);
        check("illegal_ps_no_strobe", valid_q.size() + ferr_q.size() + perr_q.size(), 0);
        bus.RX_in    = 1'b1;
        bus.prescale = 6'd8;
        idle(2);

        // back-to-back: bad stop bit, then a good frame with no idle gap
        clear_log();
        send_frame(6'd8, 6'd8, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1, base);
        send_frame(6'd8, 6'd8, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, base2);
        idle(4);
        check("b2b_second_base", base2 - base, 80);
        check("b2b_frame_err_count", ferr_q.size(), 1);
        check("b2b_frame_err_cycle", (ferr_q.size() > 0) ? ferr_q[0] - base : -1, 81);
        check("b2b_data_valid_count", valid_q.size(), 1);
        check("b2b_data_valid_cycle", (valid_q.size() > 0) ? valid_q[0] - base : -1, 161);
        check("b2b_first_idle", (fall_q.size() > 0) ? fall_q[0] - base : -1, 161);
        check("b2b_deser_count", deser_q.size(), 16);

        // asynchronous reset in the middle of data bit 4
        clear_log();
        bus.prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        for (int c = 0; c < 36; c++) begin
            bus.RX_in = (c < 8) ? 1'b0 : 1'b1;
            @(posedge CLK);
            #1;
        end
        check("pre_reset_bit_cnt", int'(bus.bit_cnt), 4);
        check("pre_reset_edge_cnt", int'(bus.edge_cnt), 3);
        #2 RST = 1'b0;
        #1 check("mid_frame_reset_outs", outs_word(), 0);
        repeat (2) @(negedge CLK);
        bus.RX_in = 1'b1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        idle(2);
        check("mid_frame_reset_no_strobe", valid_q.size() + ferr_q.size() + perr_q.size(), 0);
        clear_log();
        send_frame(6'd8, 6'd8, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, base);
        idle(4);
        check("post_reset_valid_count", valid_q.size(), 1);
        check("post_reset_valid_cycle", (valid_q.size() > 0) ? valid_q[0] - base : -1, 81);
        check("post_reset_deser_count", deser_q.size(), 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
